// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the PmodAD1 (AD7476-style) capture block: frame
// geometry, the capture FSM state type, and a helper that tests the leading
// bits of a received frame.
// No ports (package). The optional second channel is enabled elsewhere by the
// ADC_CH2_EN macro and needs nothing extra here.
// ---------------------------------------------------------------------------
package adc_pkg;

    localparam int ADC_BITS       = 12;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_e;

    // A well-formed frame starts with ADC_LEAD_ZEROS zero bits.
    function automatic logic lead_bits_err(input logic [ADC_FRAME_BITS-1:0] w);
        return |w[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS];
    endfunction

endpackage

// File: rtl/adc_capture_if.sv
// ---------------------------------------------------------------------------
// adc_capture_if
// Bundles the converter-side serial pins and the consumer-side sample
// handshake of adc_capture.
//   Start    request a conversion frame (level)
//   SCLK     serial clock to the converter
//   CSn      active-low chip select to the converter
//   SDATA    serial data from the converter, MSB first
//   Data     last captured 12-bit sample
//   Valid    Data holds an unconsumed sample
//   Ready    consumer accepts Data when Valid && Ready
//   Overrun  one-cycle pulse, an unconsumed sample was overwritten
//   FrameErr one-cycle pulse, a frame had nonzero leading bits
// With ADC_CH2_EN defined: SDATA2 (second serial input) and Data2 (its sample).
// Modports: master = capture block, slave = converter/consumer side.
// ---------------------------------------------------------------------------
interface adc_capture_if;
    import adc_pkg::*;

    logic                Start;
    logic                SCLK;
    logic                CSn;
    logic                SDATA;
    logic [ADC_BITS-1:0] Data;
    logic                Valid;
    logic                Ready;
    logic                Overrun;
    logic                FrameErr;
`ifdef ADC_CH2_EN
    logic                SDATA2;
    logic [ADC_BITS-1:0] Data2;
`endif

`ifdef ADC_CH2_EN
    modport master (
        input  Start, SDATA, SDATA2, Ready,
        output SCLK, CSn, Data, Data2, Valid, Overrun, FrameErr
    );
    modport slave (
        output Start, SDATA, SDATA2, Ready,
        input  SCLK, CSn, Data, Data2, Valid, Overrun, FrameErr
    );
`else
    modport master (
        input  Start, SDATA, Ready,
        output SCLK, CSn, Data, Valid, Overrun, FrameErr
    );
    modport slave (
        output Start, SDATA, Ready,
        input  SCLK, CSn, Data, Valid, Overrun, FrameErr
    );
`endif

endinterface

// File: rtl/adc_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen
// Serial clock generator. While en_i is high, SCLK starts high, drops after
// CLK_DIV cycles and then toggles every CLK_DIV cycles. Outside en_i SCLK
// idles high and the divider is cleared.
// Ports:
//   Clk     system clock
//   Rstn    asynchronous active-low reset
//   en_i    run the divider (high for the whole conversion)
//   sclk_o  registered serial clock
//   rise_o  high in the cycle whose closing edge drives SCLK 0->1
// ---------------------------------------------------------------------------
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Rstn,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o
);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sclk_q, sclk_d;
    logic       half_done;

    assign half_done = (div_cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!en_i) begin
            div_cnt_d = 8'd0;
            sclk_d    = 1'b1;
        end else if (half_done) begin
            div_cnt_d = 8'd0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            div_cnt_q <= 8'd0;
            sclk_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign rise_o = en_i & half_done & ~sclk_q;
    assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
// Reads 16-bit frames (4 leading zeros + 12-bit sample, MSB first) from a
// PmodAD1 converter and presents each sample with a Valid/Ready handshake.
// Frame sequence: IDLE -> CONV (CSn low, 16 SCLK rising edges) -> QUIET
// (CSn high for QUIET_CYC+1 cycles) -> IDLE.
// Ports:
//   Clk   system clock (rising edge)
//   Rstn  asynchronous active-low reset
//   bus   adc_capture_if.master: Start, SCLK, CSn, SDATA, Data, Valid,
//         Ready, Overrun, FrameErr (+ SDATA2, Data2 with ADC_CH2_EN)
// Parameters: CLK_DIV (2..255) Clk cycles per SCLK half-period,
//             QUIET_CYC (1..255) minimum CSn-high gap.
// Optional feature: define ADC_CH2_EN for a second, lock-step data channel.
// ---------------------------------------------------------------------------
module adc_capture
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic          Clk,
    input  logic          Rstn,
    adc_capture_if.master bus
);

    adc_state_e                state_q, state_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [7:0]                quiet_cnt_q, quiet_cnt_d;
    logic [ADC_FRAME_BITS-2:0] shift_q;
    logic [ADC_BITS-1:0]       data_q;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_err_q, frame_err_d;
    logic                      cs_n, sclk_en, load;
    logic                      sclk, rise, frame_done, quiet_done, lead_err;
    logic [ADC_FRAME_BITS-1:0] word;
`ifdef ADC_CH2_EN
    logic [ADC_FRAME_BITS-2:0] shift2_q;
    logic [ADC_BITS-1:0]       data2_q;
    logic [ADC_FRAME_BITS-1:0] word2;
`endif

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .Clk    (Clk),
        .Rstn   (Rstn),
        .en_i   (sclk_en),
        .sclk_o (sclk),
        .rise_o (rise)
    );

    // The last bit arrives on the 16th rising strobe; the full word is the
    // shift register plus the bit being sampled on that same edge.
    assign frame_done = rise && (bit_cnt_q == 4'(ADC_FRAME_BITS - 1));
    assign quiet_done = (quiet_cnt_q == 8'(QUIET_CYC));
    assign word       = {shift_q, bus.SDATA};
`ifdef ADC_CH2_EN
    assign word2      = {shift2_q, bus.SDATA2};
    assign lead_err   = lead_bits_err(word) | lead_bits_err(word2);
`else
    assign lead_err   = lead_bits_err(word);
`endif

    // FSM: state register
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.Start) state_d = ST_CONV;
            ST_CONV:  if (frame_done) state_d = ST_QUIET;
            ST_QUIET: if (quiet_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. CSn decodes the state register directly so that an
    // asynchronous reset raises it without waiting for a clock.
    always_comb begin
        cs_n    = 1'b1;
        sclk_en = 1'b0;
        load    = 1'b0;
        if (state_q == ST_CONV) begin
            cs_n    = 1'b0;
            sclk_en = 1'b1;
            load    = frame_done;
        end
    end

    // Counters and sample handshake next-state
    always_comb begin
        bit_cnt_d   = (state_q == ST_CONV) ? (rise ? bit_cnt_q + 4'd1 : bit_cnt_q) : 4'd0;
        quiet_cnt_d = (state_q == ST_QUIET) ? quiet_cnt_q + 8'd1 : 8'd0;

        // A fresh load wins over a same-edge handshake, so Valid stays set.
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.Ready) begin
            valid_d = 1'b0;
        end
        overrun_d   = load & valid_q & ~bus.Ready;
        frame_err_d = load & lead_err;
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            bit_cnt_q   <= 4'd0;
            quiet_cnt_q <= 8'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            if (rise) begin
                shift_q <= word[ADC_FRAME_BITS-2:0];
            end
            if (load) begin
                data_q <= word[ADC_BITS-1:0];
            end
        end
    end

`ifdef ADC_CH2_EN
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            shift2_q <= '0;
            data2_q  <= '0;
        end else begin
            if (rise) begin
                shift2_q <= word2[ADC_FRAME_BITS-2:0];
            end
            if (load) begin
                data2_q <= word2[ADC_BITS-1:0];
            end
        end
    end

    assign bus.Data2 = data2_q;
`endif

    assign bus.SCLK     = sclk;
    assign bus.CSn      = cs_n;
    assign bus.Data     = data_q;
    assign bus.Valid    = valid_q;
    assign bus.Overrun  = overrun_q;
    assign bus.FrameErr = frame_err_q;

endmodule
